// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// Request is held (addr stable) until a cycle with req=1 and ready=1.
// Memory may assert ready in the same cycle the request is raised.
interface fetch_stage_if;
   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] rdata;

   modport master (output req, output addr, input ready, input rdata);
   modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, selects next PC, handshakes with imem.
// Outputs combinational from state/inputs; PCF registered, 1 instr/cycle at zero wait.
// Stalls via StallF park a completed word in a hold buffer; redirects drain stale responses.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 StallF,
   input  logic                 PCSrcE,
   input  logic [31:0]          PCTargetE,
   fetch_stage_if.master        imem,
   output logic [31:0]          PCF,
   output logic [31:0]          PCPlus4F,
   output logic [31:0]          instr_RD,
   output logic                 InstValidF
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] hold_buf;
   logic [31:0] drain_addr;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc + 32'd4;
   assign PCF      = pc;
   assign PCPlus4F = pc_plus4;

   // Fetch FSM: PC update, hold-buffer capture and stale-response tracking.
   // A redirect always wins over StallF and loads the target immediately.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc         <= RESET_PC;
         state      <= FETCH;
         hold_buf   <= 32'h0;
         drain_addr <= 32'h0;
      end else begin
         case (state)
            FETCH: begin
               if (PCSrcE) begin
                  pc <= PCTargetE;
                  if (!imem.ready) begin
                     // request in flight must complete before the new one is issued
                     drain_addr <= pc;
                     state      <= DRAIN;
                  end
               end else if (imem.ready) begin
                  if (StallF) begin
                     hold_buf <= imem.rdata;
                     state    <= HOLD;
                  end else begin
                     pc <= pc_plus4;
                  end
               end
            end
            HOLD: begin
               if (PCSrcE) begin
                  pc       <= PCTargetE;
                  hold_buf <= 32'h0;
                  state    <= FETCH;
               end else if (!StallF) begin
                  pc    <= pc_plus4;
                  state <= FETCH;
               end
            end
            DRAIN: begin
               if (PCSrcE) begin
                  pc <= PCTargetE;
               end
               if (imem.ready) begin
                  state <= FETCH;
               end
            end
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

   // Request and presented instruction derived from state; reset silences both.
   always_comb begin
      imem.req   = 1'b0;
      imem.addr  = pc;
      InstValidF = 1'b0;
      instr_RD   = 32'h0;
      case (state)
         FETCH: begin
            imem.req   = !reset;
            imem.addr  = pc;
            InstValidF = !reset && imem.ready && !PCSrcE;
            instr_RD   = InstValidF ? imem.rdata : 32'h0;
         end
         HOLD: begin
            imem.req   = 1'b0;
            InstValidF = !reset && !PCSrcE;
            instr_RD   = InstValidF ? hold_buf : 32'h0;
         end
         DRAIN: begin
            imem.req   = !reset;
            imem.addr  = drain_addr;
         end
         default: begin
            imem.req = 1'b0;
         end
      endcase
   end

endmodule
